// File: rtl/cpucmd_fifo_writer_if.sv
// ---------------------------------------------------------------------------
// cpucmd_fifo_writer_if
//   Groups the two buses of the cpucmd_fifo write-side producer.
//   Command stream (ECPU -> writer):
//     cmd_data   word payload
//     cmd_valid  word valid
//     cmd_last   word is last of packet (qualified by valid & ready)
//     cmd_ready  writer accepts word this cycle
//   FIFO write port (writer -> cpucmd_fifo):
//     fifo_data  cpucmd_fifo Data
//     fifo_we    cpucmd_fifo WrEn
//     fifo_full  cpucmd_fifo Full
//   modport master : the ECPU/FIFO environment around the writer
//   modport slave  : the writer itself
// ---------------------------------------------------------------------------
interface cpucmd_fifo_writer_if #(
    parameter int FT_DATA_WIDTH = 32
);
    logic [FT_DATA_WIDTH-1:0] cmd_data;
    logic                     cmd_valid;
    logic                     cmd_last;
    logic                     cmd_ready;
    logic [FT_DATA_WIDTH-1:0] fifo_data;
    logic                     fifo_we;
    logic                     fifo_full;

    modport master (
        output cmd_data, cmd_valid, cmd_last, fifo_full,
        input  cmd_ready, fifo_data, fifo_we
    );

    modport slave (
        input  cmd_data, cmd_valid, cmd_last, fifo_full,
        output cmd_ready, fifo_data, fifo_we
    );
endinterface

// File: rtl/cpucmd_fifo_writer.sv
// ---------------------------------------------------------------------------
// cpucmd_fifo_writer
//   Write-side producer for cpucmd_fifo. Collects one complete ECPU packet
//   into a local buffer, then writes {tag, seq, len} header followed by the
//   payload words into the FIFO. Packets longer than MAX_WORDS are dropped.
// Ports:
//   clk               ECPU clock (= cpucmd_fifo WrClock)
//   reset             synchronous, active-high
//   bus               slave side of cpucmd_fifo_writer_if (stream + FIFO port)
//   data_incomming_o  packet being collected or emitted (to sel_a2f)
//   busy_o            FSM not idle
//   pkt_cnt_o         packets fully written to FIFO (wrapping)
//   drop_cnt_o        packets dropped for overflow (saturating)
// ---------------------------------------------------------------------------
module cpucmd_fifo_writer #(
    parameter int           FT_DATA_WIDTH = 32,
    parameter int           MAX_WORDS     = 64,
    parameter logic [7:0]   HDR_TAG       = 8'hC5
) (
    input  logic                    clk,
    input  logic                    reset,
    cpucmd_fifo_writer_if.slave     bus,
    output logic                    data_incomming_o,
    output logic                    busy_o,
    output logic [15:0]             pkt_cnt_o,
    output logic [7:0]              drop_cnt_o
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, COLLECT, HDR, PAYLOAD, DROP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      seq_q, seq_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    // Packet buffer: data only, no reset needed.
    logic [FT_DATA_WIDTH-1:0] buf_q [MAX_WORDS];

    logic          xfer;
    logic          store_en;
    logic [AW-1:0] store_addr;
    logic          last_payload;

    assign xfer       = bus.cmd_valid & bus.cmd_ready;
    assign store_en   = xfer && ((state_q == IDLE) ||
                                 ((state_q == COLLECT) && (cnt_q < MAX_CNT)));
    assign store_addr = (state_q == IDLE) ? '0 : cnt_q[AW-1:0];
    assign last_payload = ({1'b0, rd_ptr_q} == (cnt_q - CW'(1)));

    always_ff @(posedge clk) begin
        if (store_en) begin
            buf_q[store_addr] <= bus.cmd_data;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            seq_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            seq_q      <= seq_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    cnt_d   = CW'(1);
                    state_d = bus.cmd_last ? HDR : COLLECT;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    if (cnt_q == MAX_CNT) begin
                        // Overflow: the packet cannot be framed, discard it.
                        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                        state_d = bus.cmd_last ? IDLE : DROP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (bus.cmd_last) state_d = HDR;
                    end
                end
            end
            DROP: begin
                if (xfer && bus.cmd_last) state_d = IDLE;
            end
            HDR: begin
                if (bus.fifo_we) begin
                    rd_ptr_d = '0;
                    state_d  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (bus.fifo_we) begin
                    if (last_payload) begin
                        state_d   = IDLE;
                        seq_d     = seq_q + 8'd1;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: buffer read is combinational so payload words stream without gaps.
    always_comb begin
        bus.cmd_ready    = 1'b1;
        bus.fifo_we      = 1'b0;
        bus.fifo_data    = '0;
        data_incomming_o = 1'b0;
        busy_o           = (state_q != IDLE);
        unique case (state_q)
            IDLE: ;
            COLLECT: data_incomming_o = 1'b1;
            DROP: ;
            HDR: begin
                bus.cmd_ready    = 1'b0;
                data_incomming_o = 1'b1;
                bus.fifo_we      = ~bus.fifo_full;
                bus.fifo_data    = FT_DATA_WIDTH'({HDR_TAG, seq_q, 16'(cnt_q)});
            end
            PAYLOAD: begin
                bus.cmd_ready    = 1'b0;
                data_incomming_o = 1'b1;
                bus.fifo_we      = ~bus.fifo_full;
                bus.fifo_data    = buf_q[rd_ptr_q];
            end
            default: ;
        endcase
    end

    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_cpucmd_fifo_writer.sv
// ---------------------------------------------------------------------------
// tb_cpucmd_fifo_writer
//   Directed stimulus drives packets into the writer; expected FIFO words are
//   queued at stimulus time and a negedge monitor compares every FIFO write.
// ---------------------------------------------------------------------------
module tb_cpucmd_fifo_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_incomming;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb[$];
    logic [7:0]  tb_seq;

    cpucmd_fifo_writer_if #(.FT_DATA_WIDTH(32)) bus ();

    cpucmd_fifo_writer #(
        .FT_DATA_WIDTH(32),
        .MAX_WORDS(64),
        .HDR_TAG(8'hC5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .data_incomming_o(data_incomming),
        .busy_o(busy),
        .pkt_cnt_o(pkt_cnt),
        .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every FIFO write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.fifo_full) begin
            checks++;
            if (bus.fifo_we !== 1'b0) begin
                errors++;
                $display("FAIL we_while_full got we=%b required 0", bus.fifo_we);
            end
        end else if (bus.fifo_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %h required no write", bus.fifo_data);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (bus.fifo_data !== exp) begin
                    errors++;
                    $display("FAIL fifo_word got %h required %h", bus.fifo_data, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input bit last);
        int t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_last  = last;
        @(negedge clk);
        while (!bus.cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got ready=0 required ready=1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sb.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d busy=%b required 0 0", sb.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_last   = 1'b0;
        bus.cmd_data   = '0;
        bus.fifo_full  = 1'b0;
        tb_seq         = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready",    32'(bus.cmd_ready),  32'd1);
        check("rst_we",       32'(bus.fifo_we),    32'd0);
        check("rst_data",     bus.fifo_data,       32'h0);
        check("rst_incoming", 32'(data_incomming), 32'd0);
        check("rst_busy",     32'(busy),           32'd0);
        check("rst_pkt_cnt",  32'(pkt_cnt),        32'd0);
        check("rst_drop_cnt", 32'(drop_cnt),       32'd0);
        @(posedge clk);
        #1;

        // 3-word packet, FIFO never full: header + A,B,C on consecutive cycles
        sb.push_back(32'hC500_0003);
        sb.push_back(32'hAAAA_0001);
        sb.push_back(32'hBBBB_0002);
        sb.push_back(32'hCCCC_0003);
        send_word(32'hAAAA_0001, 1'b0);
        check("collect_incoming", 32'(data_incomming), 32'd1);
        send_word(32'hBBBB_0002, 1'b0);
        send_word(32'hCCCC_0003, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_we", 32'(bus.fifo_we), 32'd1);
            if (i == 0) check("hdr_ready", 32'(bus.cmd_ready), 32'd0);
        end
        wait_idle();
        check("pkt_cnt_1", 32'(pkt_cnt), 32'd1);
        check("idle_incoming", 32'(data_incomming), 32'd0);

        // Same packet, FIFO full for 4 cycles from the 2nd payload word
        sb.push_back(32'hC501_0003);
        sb.push_back(32'hAAAA_0001);
        sb.push_back(32'hBBBB_0002);
        sb.push_back(32'hCCCC_0003);
        send_word(32'hAAAA_0001, 1'b0);
        send_word(32'hBBBB_0002, 1'b0);
        send_word(32'hCCCC_0003, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 bus.fifo_full = 1'b1;
        @(negedge clk);
        check("stall_data_held", bus.fifo_data, 32'hBBBB_0002);
        repeat (4) @(posedge clk);
        #1 bus.fifo_full = 1'b0;
        wait_idle();
        check("pkt_cnt_2", 32'(pkt_cnt), 32'd2);

        // 70-word packet overflows and is dropped; following 1-word packet goes out
        for (int i = 0; i < 70; i++) send_word(32'hDD00_0000 + 32'(i), i == 69);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_cnt_1", 32'(drop_cnt), 32'd1);
        check("drop_pkt_cnt", 32'(pkt_cnt), 32'd2);
        sb.push_back(32'hC502_0001);
        sb.push_back(32'h1234_5678);
        send_word(32'h1234_5678, 1'b1);
        wait_idle();
        check("pkt_cnt_3", 32'(pkt_cnt), 32'd3);

        // Exactly 64 words: accepted, len=0x40
        sb.push_back(32'hC503_0040);
        for (int i = 0; i < 64; i++) sb.push_back(32'h6400_0000 + 32'(i));
        for (int i = 0; i < 64; i++) send_word(32'h6400_0000 + 32'(i), i == 63);
        wait_idle();
        check("max_drop_cnt", 32'(drop_cnt), 32'd1);
        check("pkt_cnt_4", 32'(pkt_cnt), 32'd4);

        // Reset during PAYLOAD: header + 2 words written, then nothing
        sb.push_back(32'hC504_0005);
        sb.push_back(32'h5000_0000);
        sb.push_back(32'h5000_0001);
        for (int i = 0; i < 5; i++) send_word(32'h5000_0000 + 32'(i), i == 4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstmid_we",       32'(bus.fifo_we),    32'd0);
        check("rstmid_data",     bus.fifo_data,       32'h0);
        check("rstmid_ready",    32'(bus.cmd_ready),  32'd1);
        check("rstmid_busy",     32'(busy),           32'd0);
        check("rstmid_incoming", 32'(data_incomming), 32'd0);
        check("rstmid_pkt_cnt",  32'(pkt_cnt),        32'd0);
        check("rstmid_drop_cnt", 32'(drop_cnt),       32'd0);
        check("rstmid_pending",  32'(sb.size()),      32'd0);
        @(posedge clk);
        #1;

        // First packet after reset has seq 00; 257 single-word packets wrap seq
        tb_seq = 8'h00;
        for (int i = 0; i < 257; i++) begin
            sb.push_back({8'hC5, tb_seq, 16'h0001});
            sb.push_back(32'h7000_0000 + 32'(i));
            send_word(32'h7000_0000 + 32'(i), 1'b1);
            tb_seq = tb_seq + 8'd1;
        end
        wait_idle();
        check("pkt_cnt_257", 32'(pkt_cnt), 32'd257);
        check("final_pending", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
